vga_sync_800x600: RTL and testbench

//  SVGA 800x600 @ 56.25 Hz raster timing generator, clocked by the 36 MHz pixel clock

---
 rtl/vga_sync_800x600.sv | 107 ++++++++++
 tb/tb_vga_sync_800x600.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_800x600.sv
// SVGA 800x600 @ 56.25 Hz raster timing generator on the 36 MHz pixel clock.
// Supplies registered syncs plus zero-latency pixel coordinates and frame markers to the renderer.
module vga_sync_800x600 #(
  parameter int   H_VISIBLE  = 800,
  parameter int   H_FRONT    = 24,
  parameter int   H_SYNC     = 72,
  parameter int   H_BACK     = 128,
  parameter int   V_VISIBLE  = 600,
  parameter int   V_FRONT    = 1,
  parameter int   V_SYNC     = 2,
  parameter int   V_BACK     = 22,
  parameter logic H_SYNC_POL = 1'b1,
  parameter logic V_SYNC_POL = 1'b1
) (
  input  logic        clk_36MHz,
  input  logic        reset,
  output logic        hsync,
  output logic        vsync,
  output logic [10:0] x_px,
  output logic [10:0] y_px,
  output logic        active_video,
  output logic        frame_start,
  output logic        vblank_start,
  output logic [7:0]  frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [10:0] H_LAST       = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST       = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS_END    = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS_END    = 11'(V_VISIBLE);
  localparam logic [10:0] H_SYNC_START = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] H_SYNC_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] V_SYNC_START = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] V_SYNC_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [10:0] x_r;
  logic [10:0] y_r;
  logic [7:0]  frame_count_r;
  logic        run_r;
  logic        hsync_r;
  logic        vsync_r;

  logic        x_last_s;
  logic        y_last_s;
  logic        hsync_win_s;
  logic        vsync_win_s;
  logic        active_s;
  logic        frame_start_s;
  logic        vblank_start_s;

  // Position decodes; everything is gated by run so an idle generator shows no markers.
  always_comb begin
    x_last_s       = (x_r == H_LAST);
    y_last_s       = (y_r == V_LAST);
    hsync_win_s    = run_r && (x_r >= H_SYNC_START) && (x_r < H_SYNC_END);
    vsync_win_s    = run_r && (y_r >= V_SYNC_START) && (y_r < V_SYNC_END);
    active_s       = run_r && (x_r < H_VIS_END) && (y_r < V_VIS_END);
    frame_start_s  = run_r && (x_r == 11'd0) && (y_r == 11'd0);
    vblank_start_s = run_r && (x_r == 11'd0) && (y_r == V_VIS_END);
  end

  // Raster counters: the first edge out of reset only arms run, so pixel (0,0) lasts one full cycle.
  always_ff @(posedge clk_36MHz) begin
    if (reset) begin
      x_r           <= 11'd0;
      y_r           <= 11'd0;
      run_r         <= 1'b0;
      frame_count_r <= 8'd0;
    end else if (!run_r) begin
      run_r <= 1'b1;
    end else if (x_last_s) begin
      x_r <= 11'd0;
      if (y_last_s) begin
        y_r           <= 11'd0;
        frame_count_r <= frame_count_r + 8'd1;
      end else begin
        y_r <= y_r + 11'd1;
      end
    end else begin
      x_r <= x_r + 11'd1;
    end
  end

  // Sync flops: one cycle behind the coordinates so the connector sees glitch-free edges.
  always_ff @(posedge clk_36MHz) begin
    if (reset) begin
      hsync_r <= ~H_SYNC_POL;
      vsync_r <= ~V_SYNC_POL;
    end else begin
      hsync_r <= hsync_win_s ? H_SYNC_POL : ~H_SYNC_POL;
      vsync_r <= vsync_win_s ? V_SYNC_POL : ~V_SYNC_POL;
    end
  end

  assign hsync        = hsync_r;
  assign vsync        = vsync_r;
  assign x_px         = x_r;
  assign y_px         = y_r;
  assign frame_count  = frame_count_r;
  assign active_video = active_s;
  assign frame_start  = frame_start_s;
  assign vblank_start = vblank_start_s;

endmodule

// File: tb/tb_vga_sync_800x600.sv
// Directed bench: full-size instance for line timing, two shrunken instances (16x12 raster,
// active-high and active-low syncs) for frame, wrap and mid-frame reset behaviour.
module tb_vga_sync_800x600;

  logic clk_36MHz = 1'b0;
  logic rst_a = 1'b1;
  logic rst_s = 1'b1;

  logic        hsync_a, vsync_a, active_a, fs_a, vb_a;
  logic [10:0] x_a, y_a;
  logic [7:0]  fc_a;
  logic        hsync_b, vsync_b, active_b, fs_b, vb_b;
  logic [10:0] x_b, y_b;
  logic [7:0]  fc_b;
  logic        hsync_c, vsync_c, active_c, fs_c, vb_c;
  logic [10:0] x_c, y_c;
  logic [7:0]  fc_c;

  int total = 0;
  int bad   = 0;

  // Small-raster monitor state
  int s_cyc, rises, first_rise, last_rise, vs_len, width_bad, period_bad;
  int hs_hi, c_vs_lo, c_hs_lo, vb_pulses, vb_at, fs_count, fs_at, overlap_bad;
  logic prev_vs;

  vga_sync_800x600 dut_a (
    .clk_36MHz(clk_36MHz), .reset(rst_a), .hsync(hsync_a), .vsync(vsync_a),
    .x_px(x_a), .y_px(y_a), .active_video(active_a), .frame_start(fs_a),
    .vblank_start(vb_a), .frame_count(fc_a));

  vga_sync_800x600 #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(4),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(3),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1)
  ) dut_b (
    .clk_36MHz(clk_36MHz), .reset(rst_s), .hsync(hsync_b), .vsync(vsync_b),
    .x_px(x_b), .y_px(y_b), .active_video(active_b), .frame_start(fs_b),
    .vblank_start(vb_b), .frame_count(fc_b));

  vga_sync_800x600 #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(4),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(3),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0)
  ) dut_c (
    .clk_36MHz(clk_36MHz), .reset(rst_s), .hsync(hsync_c), .vsync(vsync_c),
    .x_px(x_c), .y_px(y_c), .active_video(active_c), .frame_start(fs_c),
    .vblank_start(vb_c), .frame_count(fc_c));

  always #5 clk_36MHz = ~clk_36MHz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_36MHz);
    #1;
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic sample_s();
    if (vsync_b && !prev_vs) begin
      rises++;
      if (first_rise < 0) first_rise = s_cyc;
      else if (s_cyc - last_rise != 192) period_bad++;
      last_rise = s_cyc;
      vs_len = 0;
    end
    if (vsync_b) vs_len++;
    if (!vsync_b && prev_vs && vs_len != 32) width_bad++;
    prev_vs = vsync_b;
    if (hsync_b) hs_hi++;
    if (!vsync_c) c_vs_lo++;
    if (!hsync_c) c_hs_lo++;
    if (vb_b) begin vb_pulses++; vb_at = s_cyc; end
    if (fs_b) begin fs_count++; fs_at = s_cyc; end
    if ((fs_b && vb_b) || (vb_b && active_b)) overlap_bad++;
  endtask

  task automatic tick_s(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      s_cyc++;
      sample_s();
    end
  endtask

  initial begin
    // Reset held 3 cycles
    #1;
    run_n(3);
    check("rst_x", x_a, 0);
    check("rst_y", y_a, 0);
    check("rst_active", active_a, 0);
    check("rst_fs", fs_a, 0);
    check("rst_hsync", hsync_a, 0);
    check("rst_vsync", vsync_a, 0);
    check("rst_fc", fc_a, 0);
    check("rst_c_hsync_idle", hsync_c, 1);
    check("rst_c_vsync_idle", vsync_c, 1);
    check("rst_b_fs", fs_b, 0);

    rst_a = 1'b0;
    tick();
    check("c1_x", x_a, 0);
    check("c1_y", y_a, 0);
    check("c1_active", active_a, 1);
    check("c1_fs", fs_a, 1);
    tick();
    check("c2_x", x_a, 1);
    check("c2_fs", fs_a, 0);

    // One full-size line
    run_n(798);
    check("x799_active", active_a, 1);
    tick();
    check("x800_x", x_a, 800);
    check("x800_active", active_a, 0);
    run_n(24);
    check("x824_hsync", hsync_a, 0);
    tick();
    check("x825_hsync", hsync_a, 1);
    run_n(71);
    check("x896_x", x_a, 896);
    check("x896_hsync", hsync_a, 1);
    tick();
    check("x897_hsync", hsync_a, 0);
    run_n(126);
    check("x1023_x", x_a, 1023);
    check("x1023_y", y_a, 0);
    tick();
    check("wrap_x", x_a, 0);
    check("wrap_y", y_a, 1);
    check("line_vsync", vsync_a, 0);

    // Small raster: one frame
    rst_s = 1'b0;
    tick();
    check("s_start_fs", fs_b, 1);
    check("s_start_active", active_b, 1);
    check("s_start_c_fs", fs_c, 1);
    s_cyc = 0; rises = 0; first_rise = -1; last_rise = 0; vs_len = 0;
    width_bad = 0; period_bad = 0; hs_hi = 0; c_vs_lo = 0; c_hs_lo = 0;
    vb_pulses = 0; vb_at = -1; fs_count = 0; fs_at = -1; overlap_bad = 0;
    prev_vs = vsync_b;
    tick_s(192);
    check("f1_vsync_first", first_rise, 113);
    check("f1_vsync_rises", rises, 1);
    check("f1_vsync_width_bad", width_bad, 0);
    check("f1_hsync_hi", hs_hi, 24);
    check("f1_c_vsync_lo", c_vs_lo, 32);
    check("f1_c_hsync_lo", c_hs_lo, 24);
    check("f1_vblank_count", vb_pulses, 1);
    check("f1_vblank_at", vb_at, 96);
    check("f1_fs_count", fs_count, 1);
    check("f1_fs_at", fs_at, 192);
    check("f1_fc", fc_b, 1);
    check("f1_x", x_b, 0);
    check("f1_y", y_b, 0);

    // 255 more frames: wrap of frame_count
    tick_s(255 * 192 - 1);
    check("pre_wrap_fc", fc_b, 255);
    tick_s(1);
    check("wrap_fc", fc_b, 0);
    check("wrap_fs", fs_b, 1);
    check("run_rises", rises, 256);
    check("run_period_bad", period_bad, 0);
    check("run_width_bad", width_bad, 0);
    check("run_vblank_count", vb_pulses, 256);
    check("run_fs_count", fs_count, 256);
    check("run_overlap_bad", overlap_bad, 0);

    // Mid-frame reset while hsync is active
    run_n(75);
    check("mid_x", x_b, 11);
    check("mid_y", y_b, 4);
    check("mid_hsync_b", hsync_b, 1);
    check("mid_hsync_c", hsync_c, 0);
    rst_s = 1'b1;
    tick();
    rst_s = 1'b0;
    check("mr_x", x_b, 0);
    check("mr_y", y_b, 0);
    check("mr_active", active_b, 0);
    check("mr_fs", fs_b, 0);
    check("mr_hsync_b", hsync_b, 0);
    check("mr_hsync_c", hsync_c, 1);
    check("mr_vsync_c", vsync_c, 1);
    tick();
    check("mr_next_fs", fs_b, 1);
    check("mr_next_fc", fc_b, 0);
    check("mr_next_x", x_b, 0);
    tick();
    check("mr_x1", x_b, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
